// File: rtl/arythcrypt_pkg.sv
// Shared types and keystream helpers for the arithmetic crypto core (encrypt and decrypt sides).
package arythcrypt_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic {
        NOKEY = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Taps 7,5,4,3: x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [DATA_W-1:0] LFSR_TAPS         = 8'hB8;
    localparam logic [DATA_W-1:0] SEED_ZERO_DEFAULT = 8'h01;

    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] s);
        return {s[DATA_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/arythcrypt_lfsr.sv
// 8-bit keystream LFSR: load has priority over step.
module arythcrypt_lfsr
    import arythcrypt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              step,
    output logic [DATA_W-1:0] state
);

    logic [DATA_W-1:0] s_q, s_d;

    always_comb begin
        s_d = s_q;
        if (load) begin
            s_d = seed;
        end else if (step) begin
            s_d = lfsr_next(s_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    assign state = s_q;

endmodule

// File: rtl/arythcrypt_decoder.sv
// Stream decryptor: P = ((C - S) mod 256) ^ K with a per-byte LFSR keystream S.
module arythcrypt_decoder
    import arythcrypt_pkg::*;
#(
    parameter logic [DATA_W-1:0] SEED_ZERO_SUB = SEED_ZERO_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              key_load,
    input  logic [DATA_W-1:0] key_in,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              keyed,
    output logic [DATA_W-1:0] byte_cnt
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;

    logic              lfsr_load, lfsr_step;
    logic [DATA_W-1:0] lfsr_seed, lfsr_s;
    logic              in_ready_c, accept_c;

    arythcrypt_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (lfsr_seed),
        .step  (lfsr_step),
        .state (lfsr_s)
    );

    // Key load blocks acceptance so the upstream holds its byte across a rekey.
    assign in_ready_c = ena & (state_q == RUN) & ~key_load & (~out_valid_q | out_ready);
    assign accept_c   = in_valid & in_ready_c;
    assign lfsr_seed  = (key_in == '0) ? SEED_ZERO_SUB : key_in;

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cnt_d       = cnt_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        if (ena) begin
            if (key_load) begin
                state_d     = RUN;
                key_d       = key_in;
                out_valid_d = 1'b0;
                cnt_d       = '0;
                lfsr_load   = 1'b1;
            end else begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (accept_c) begin
                    out_data_d  = DATA_W'(in_data - lfsr_s) ^ key_q;
                    out_valid_d = 1'b1;
                    cnt_d       = DATA_W'(cnt_q + 8'd1);
                    lfsr_step   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= NOKEY;
            key_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign keyed     = (state_q == RUN);
    assign byte_cnt  = cnt_q;

endmodule

// File: tb/tb_arythcrypt_decoder.sv
// Directed bench for arythcrypt_decoder with hand-computed plaintext vectors.
module tb_arythcrypt_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       key_load;
    logic [7:0] key_in;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       keyed;
    logic [7:0] byte_cnt;

    int pass_cnt = 0;
    int total    = 0;

    arythcrypt_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .keyed     (keyed),
        .byte_cnt  (byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [7:0] k);
        key_load = 1'b1;
        key_in   = k;
        cyc();
        key_load = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; key_load = 1'b0; key_in = 8'h00;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 8'(in_ready), 8'h00);
        chk("rst_out_valid", 8'(out_valid), 8'h00);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_keyed", 8'(keyed), 8'h00);
        chk("rst_byte_cnt", byte_cnt, 8'h00);
        rst_n = 1'b1;

        // No key yet: bytes are refused
        in_valid = 1'b1; in_data = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("nokey_in_ready", 8'(in_ready), 8'h00);
            chk("nokey_out_valid", 8'(out_valid), 8'h00);
        end
        in_valid = 1'b0;

        // Key 3C, back-to-back B9, B5 -> 41, 00
        load_key(8'h3C);
        chk("key_keyed", 8'(keyed), 8'h01);
        chk("key_cnt", byte_cnt, 8'h00);
        chk("key_in_ready", 8'(in_ready), 8'h01);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hB9;
        cyc();
        chk("b2b_valid0", 8'(out_valid), 8'h01);
        chk("b2b_data0", out_data, 8'h41);
        chk("b2b_cnt0", byte_cnt, 8'h01);
        chk("b2b_lfsr", dut.u_lfsr.state, 8'h79);
        in_data = 8'hB5;
        cyc();
        chk("b2b_valid1", 8'(out_valid), 8'h01);
        chk("b2b_data1", out_data, 8'h00);
        chk("b2b_cnt1", byte_cnt, 8'h02);
        in_valid = 1'b0;
        cyc();
        chk("drain_valid", 8'(out_valid), 8'h00);

        // Subtract wrap: 10 - 3C = D4, ^3C = E8
        load_key(8'h3C);
        in_valid = 1'b1; in_data = 8'h10;
        cyc();
        in_valid = 1'b0;
        chk("wrap_data", out_data, 8'hE8);
        chk("wrap_cnt", byte_cnt, 8'h01);

        // Zero key uses seed 01
        load_key(8'h00);
        in_valid = 1'b1; in_data = 8'h05;
        cyc();
        in_valid = 1'b0;
        chk("zkey_data", out_data, 8'h04);
        chk("zkey_keyed", 8'(keyed), 8'h01);

        // Backpressure
        load_key(8'h3C);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hB9;
        cyc();
        in_data = 8'hB5;
        #1;
        chk("bp_in_ready", 8'(in_ready), 8'h00);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_hold_data", out_data, 8'h41);
            chk("bp_hold_valid", 8'(out_valid), 8'h01);
            chk("bp_hold_cnt", byte_cnt, 8'h01);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 8'(in_ready), 8'h01);
        cyc();
        chk("bp_next_data", out_data, 8'h00);
        chk("bp_next_valid", 8'(out_valid), 8'h01);
        chk("bp_next_cnt", byte_cnt, 8'h02);
        in_valid = 1'b0;
        cyc();

        // Clock enable low: nothing moves
        ena = 1'b0; in_valid = 1'b1; in_data = 8'h77;
        #1;
        chk("ena_in_ready", 8'(in_ready), 8'h00);
        cyc();
        chk("ena_cnt_hold", byte_cnt, 8'h02);
        chk("ena_valid_hold", 8'(out_valid), 8'h00);
        ena = 1'b1; in_valid = 1'b0;

        // Key load beats in_valid; pending output dropped
        load_key(8'h3C);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hB9;
        cyc();
        chk("pri_pending", 8'(out_valid), 8'h01);
        key_load = 1'b1; key_in = 8'h3C; in_data = 8'hB5;
        #1;
        chk("pri_in_ready", 8'(in_ready), 8'h00);
        cyc();
        chk("pri_dropped", 8'(out_valid), 8'h00);
        chk("pri_cnt", byte_cnt, 8'h00);
        key_load = 1'b0; in_data = 8'hB9;
        cyc();
        in_valid = 1'b0;
        chk("pri_reseed_data", out_data, 8'h41);
        chk("pri_reseed_cnt", byte_cnt, 8'h01);

        // Asynchronous reset with a byte held
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 8'(out_valid), 8'h00);
        chk("arst_out_data", out_data, 8'h00);
        chk("arst_keyed", 8'(keyed), 8'h00);
        chk("arst_cnt", byte_cnt, 8'h00);
        chk("arst_in_ready", 8'(in_ready), 8'h00);
        #1;
        rst_n = 1'b1;

        // byte_cnt wrap after 256 accepts
        load_key(8'h3C);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h00;
        for (int i = 0; i < 255; i++) cyc();
        chk("cnt_ff", byte_cnt, 8'hFF);
        cyc();
        in_valid = 1'b0;
        chk("cnt_wrap", byte_cnt, 8'h00);
        chk("cnt_wrap_valid", 8'(out_valid), 8'h01);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
